// File: rtl/sa_output_deskew.sv
// Realigns the column-skewed bottom-row outputs of the systolic array into whole rows,
// buffers them in a small FIFO and serialises each row word by word over valid/ready.
module sa_output_deskew #(
    parameter int SA_SIZE   = 8,
    parameter int DATA_W    = 32,
    parameter int FIFO_ROWS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stream_advance,
    input  logic                              vec_start,
    input  logic [SA_SIZE-1:0][DATA_W-1:0]    sa_outputs,
    output logic                              stream_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [$clog2(FIFO_ROWS+1)-1:0]    fifo_level,
    output logic                              overflow_err,
    input  logic                              err_clear
);

    localparam int LAT   = 2 * (SA_SIZE - 1);
    localparam int LVL_W = $clog2(FIFO_ROWS + 1);
    localparam int IF_W  = $clog2(LAT + 1);
    localparam int PTR_W = (FIFO_ROWS > 1) ? $clog2(FIFO_ROWS) : 1;
    localparam int COL_W = $clog2(SA_SIZE);

    logic [SA_SIZE-1:0][DATA_W-1:0] row_words;

    // Column c waits SA_SIZE-1-c advances so every column lines up with the live last column.
    generate
        for (genvar gi = 0; gi < SA_SIZE - 1; gi++) begin : g_delay
            localparam int D = SA_SIZE - 1 - gi;
            logic [D-1:0][DATA_W-1:0] dl_q;
            logic [D-1:0][DATA_W-1:0] dl_d;

            always_comb begin
                dl_d = dl_q;
                if (stream_advance) begin
                    dl_d[0] = sa_outputs[gi];
                    for (int j = 1; j < D; j++) begin
                        dl_d[j] = dl_q[j-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dl_q <= '0;
                end else begin
                    dl_q <= dl_d;
                end
            end

            assign row_words[gi] = dl_q[D-1];
        end
    endgenerate

    assign row_words[SA_SIZE-1] = sa_outputs[SA_SIZE-1];

    logic [LAT-1:0]    tag_q, tag_d;
    logic [IF_W-1:0]   inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  fifo_level_q, fifo_level_d;
    logic [COL_W-1:0]  col_idx_q, col_idx_d;
    logic              overflow_err_q, overflow_err_d;
    logic              tag_in, tag_out, full, pop, wr_en, ovf;

    logic [SA_SIZE-1:0][DATA_W-1:0] fifo_mem [FIFO_ROWS];
    logic [SA_SIZE-1:0][DATA_W-1:0] head_row;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_ROWS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        tag_in  = stream_advance & vec_start;
        tag_out = stream_advance & tag_q[LAT-1];
        full    = (fifo_level_q == LVL_W'(FIFO_ROWS));
        pop     = out_valid & out_ready & (col_idx_q == COL_W'(SA_SIZE - 1));
        // A pop in the same edge frees the slot, so a full FIFO can still accept the row.
        wr_en   = tag_out & (~full | pop);
        ovf     = tag_out & full & ~pop;

        tag_d = tag_q;
        if (stream_advance) begin
            tag_d = {tag_q[LAT-2:0], vec_start};
        end

        inflight_d = inflight_q;
        case ({tag_in, tag_out})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        fifo_level_d = fifo_level_q;
        case ({wr_en, pop})
            2'b10:   fifo_level_d = fifo_level_q + LVL_W'(1);
            2'b01:   fifo_level_d = fifo_level_q - LVL_W'(1);
            default: fifo_level_d = fifo_level_q;
        endcase

        col_idx_d = col_idx_q;
        if (out_valid & out_ready) begin
            col_idx_d = pop ? '0 : col_idx_q + COL_W'(1);
        end

        overflow_err_d = overflow_err_q;
        if (ovf) begin
            overflow_err_d = 1'b1;
        end else if (err_clear) begin
            overflow_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q          <= '0;
            inflight_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_level_q   <= '0;
            col_idx_q      <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            tag_q          <= tag_d;
            inflight_q     <= inflight_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_level_q   <= fifo_level_d;
            col_idx_q      <= col_idx_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Row storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= row_words;
        end
    end

    always_comb begin
        head_row     = fifo_mem[rd_ptr_q];
        out_valid    = (fifo_level_q != '0);
        out_data     = out_valid ? head_row[col_idx_q] : '0;
        out_last     = out_valid & (col_idx_q == COL_W'(SA_SIZE - 1));
        fifo_level   = fifo_level_q;
        overflow_err = overflow_err_q;
        stream_ready = (32'(fifo_level_q) + 32'(inflight_q)) < 32'(FIFO_ROWS);
    end

endmodule

// File: tb/tb_sa_output_deskew.sv
// Bench for sa_output_deskew (4x4 array, 2-row FIFO): directed scenarios plus a random
// phase, each cycle compared with a row/queue model built from the skew rules.
module tb_sa_output_deskew;

    localparam int S  = 4;
    localparam int FR = 2;

    typedef logic [S-1:0][31:0] row_t;

    logic        clk = 1'b0;
    logic        reset, stream_advance, vec_start, out_ready, err_clear;
    row_t        sa_outputs;
    logic        stream_ready, out_valid, out_last, overflow_err;
    logic [31:0] out_data;
    logic [1:0]  fifo_level;

    int vectors = 0;
    int miscompares = 0;

    row_t        hist [0:8191];
    int          adv_cnt = 0;
    int          tags[$];
    row_t        mq[$];
    int          m_col = 0;
    bit          m_err = 0;
    logic [32:0] seen[$];

    sa_output_deskew #(.SA_SIZE(S), .DATA_W(32), .FIFO_ROWS(FR)) dut (
        .clk(clk), .reset(reset), .stream_advance(stream_advance), .vec_start(vec_start),
        .sa_outputs(sa_outputs), .stream_ready(stream_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .fifo_level(fifo_level), .overflow_err(overflow_err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic row_t rnd_row();
        row_t r;
        for (int c = 0; c < S; c++) r[c] = $urandom;
        return r;
    endfunction

    // Single-vector pattern: column c carries 0x100+c at relative advance 3+c.
    function automatic row_t mk(input int rel);
        row_t r;
        for (int c = 0; c < S; c++) r[c] = (rel == 3 + c) ? 32'h100 + 32'(c) : 32'h0;
        return r;
    endfunction

    task automatic step(input bit adv, input bit vs, input row_t din, input bit rdy,
                        input bit clr, input bit rst);
        stream_advance = adv;
        vec_start      = vs;
        sa_outputs     = din;
        out_ready      = rdy;
        err_clear      = clr;
        reset          = rst;
        if (!rst && out_valid && rdy) seen.push_back({out_last, out_data});
        @(posedge clk);
        if (rst) begin
            mq.delete();
            tags.delete();
            m_col = 0;
            m_err = 0;
        end else begin
            bit ovf;
            ovf = 0;
            if (mq.size() > 0 && rdy) begin
                if (m_col == S - 1) begin
                    m_col = 0;
                    void'(mq.pop_front());
                end else begin
                    m_col++;
                end
            end
            if (adv) begin
                hist[adv_cnt] = din;
                if (tags.size() > 0 && tags[0] + 2 * (S - 1) == adv_cnt) begin
                    row_t r;
                    for (int c = 0; c < S; c++) r[c] = hist[tags[0] + (S - 1) + c][c];
                    void'(tags.pop_front());
                    if (mq.size() < FR) mq.push_back(r);
                    else ovf = 1;
                end
                if (vs) tags.push_back(adv_cnt);
                adv_cnt++;
            end
            if (ovf) m_err = 1;
            else if (clr) m_err = 0;
        end
        #1;
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("data", out_data, (mq.size() != 0) ? mq[0][m_col] : 32'h0);
        chk("last", 32'(out_last), 32'(mq.size() != 0 && m_col == S - 1));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("ready", 32'(stream_ready), 32'((mq.size() + tags.size()) < FR));
        chk("ovf_err", 32'(overflow_err), 32'(m_err));
    endtask

    task automatic run_single(input int gap, input string name);
        seen.delete();
        for (int rel = 0; rel <= 6; rel++) begin
            step(1, rel == 0, mk(rel), 0, 0, 0);
            if (rel < 6) repeat (gap) step(0, 0, '0, 0, 0, 0);
        end
        chk({name, "_level1"}, 32'(fifo_level), 32'd1);
        repeat (4) step(0, 0, '0, 1, 0, 0);
        chk({name, "_count"}, 32'(seen.size()), 32'd4);
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            chk({name, "_word"}, seen[i][31:0], 32'h100 + 32'(i));
            chk({name, "_lastflag"}, 32'(seen[i][32]), 32'(i == 3));
        end
        chk({name, "_level0"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        reset = 1'b1; stream_advance = 1'b0; vec_start = 1'b0;
        sa_outputs = '0; out_ready = 1'b0; err_clear = 1'b0;

        // Reset state
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        chk("rst_ready", 32'(stream_ready), 32'd1);
        chk("rst_data", out_data, 32'h0);

        // Single vector, then the same with 3-cycle gaps between advances
        run_single(0, "single");
        run_single(3, "gaps");

        // Credit: two vectors with the reader stalled
        step(1, 1, rnd_row(), 0, 0, 0);
        step(1, 1, rnd_row(), 0, 0, 0);
        chk("credit_low", 32'(stream_ready), 32'd0);
        repeat (6) step(1, 0, rnd_row(), 0, 0, 0);
        chk("credit_full", 32'(fifo_level), 32'd2);
        chk("credit_still_low", 32'(stream_ready), 32'd0);
        repeat (4) step(0, 0, '0, 1, 0, 0);
        chk("credit_back", 32'(stream_ready), 32'd1);

        // Refill to full, then force one more row: it must be dropped
        step(1, 1, rnd_row(), 0, 0, 0);
        repeat (6) step(1, 0, rnd_row(), 0, 0, 0);
        chk("ovf_prefull", 32'(fifo_level), 32'd2);
        step(1, 1, rnd_row(), 0, 0, 0);
        repeat (6) step(1, 0, rnd_row(), 0, 0, 0);
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd2);
        repeat (3) step(0, 0, '0, 0, 0, 0);
        chk("ovf_held", 32'(overflow_err), 32'd1);
        step(0, 0, '0, 0, 1, 0);
        chk("ovf_cleared", 32'(overflow_err), 32'd0);
        repeat (8) step(0, 0, '0, 1, 0, 0);
        chk("ovf_drained", 32'(fifo_level), 32'd0);

        // Full FIFO: last word pops on the same edge a new row lands
        step(1, 1, rnd_row(), 0, 0, 0);
        step(1, 1, rnd_row(), 0, 0, 0);
        step(1, 1, rnd_row(), 0, 0, 0);
        repeat (5) step(1, 0, rnd_row(), 0, 0, 0);
        chk("pp_full", 32'(fifo_level), 32'd2);
        repeat (3) step(0, 0, '0, 1, 0, 0);
        chk("pp_at_last", 32'(out_last), 32'd1);
        step(1, 0, rnd_row(), 1, 0, 0);
        chk("pp_level", 32'(fifo_level), 32'd2);
        chk("pp_no_err", 32'(overflow_err), 32'd0);
        repeat (8) step(0, 0, '0, 1, 0, 0);
        chk("pp_drained", 32'(fifo_level), 32'd0);

        // Reset in the middle of a vector, then a clean vector
        for (int rel = 0; rel < 4; rel++) step(1, rel == 0, mk(rel), 0, 0, 0);
        step(1, 0, mk(4), 0, 0, 1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_ready", 32'(stream_ready), 32'd1);
        step(0, 0, '0, 0, 0, 0);
        run_single(0, "after_rst");

        // Random traffic, occasionally ignoring credit
        repeat (600) begin
            bit adv, vs;
            adv = ($urandom % 2) == 0;
            vs  = adv && (stream_ready || ($urandom % 16) == 0) && (($urandom % 2) == 0);
            step(adv, vs, rnd_row(), ($urandom % 4) != 0, ($urandom % 32) == 0,
                 ($urandom % 300) == 0);
        end
        repeat (8) step(1, 0, rnd_row(), 1, 0, 0);
        repeat (20) step(0, 0, '0, 1, 0, 0);
        chk("final_empty", 32'(fifo_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
